// File: rtl/sram_pp_pkg.sv
// Shared types and constants for the ping-pong SRAM arbiter.
// Bank FSM states, bank indices and access direction encoding.
package sram_pp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bank_state_e;

  localparam logic BANK0     = 1'b0;
  localparam logic BANK1     = 1'b1;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/sram_bank_port.sv
// One async-SRAM bank port: IDLE -> ACCESS (ACC_CYC cycles) -> DONE -> IDLE.
// Strobes are registered from the next state so they never glitch.
module sram_bank_port
  import sram_pp_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int ACC_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              start_dir,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [DATA_W-1:0] start_data,
  output logic              idle,
  output logic              finish_s,
  output logic              dir,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int CNT_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYC - 1);

  bank_state_e      state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             dir_r, dir_nxt_s;

  assign idle = (state_r == ST_IDLE);
  assign dir  = dir_r;

  // State, cycle counter and direction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      dir_r   <= DIR_READ;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dir_r   <= dir_nxt_s;
    end
  end

  // Next-state logic; finish_s flags the last ACCESS cycle
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    dir_nxt_s   = dir_r;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_ACCESS;
          cnt_nxt_s   = '0;
          dir_nxt_s   = start_dir;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
          finish_s    = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Address/data latch at grant and strobes derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      if (state_r == ST_IDLE && start) begin
        sram_addr   <= start_addr;
        sram_dq_out <= start_data;
      end
      sram_ce_n  <= (state_nxt_s != ST_ACCESS);
      sram_we_n  <= !(state_nxt_s == ST_ACCESS && dir_nxt_s == DIR_WRITE);
      sram_oe_n  <= !(state_nxt_s == ST_ACCESS && dir_nxt_s == DIR_READ);
      sram_dq_oe <= (state_nxt_s == ST_ACCESS && dir_nxt_s == DIR_WRITE);
    end
  end

endmodule

// File: rtl/sram_pingpong_arbiter.sv
// Ping-pong SRAM frame store: one writer on the write bank, NUM_RD round-robin
// readers on the display bank, frame-synchronous bank swap with freeze.
module sram_pingpong_arbiter
  import sram_pp_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int NUM_RD  = 2,
  parameter int ACC_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  input  logic                     wr_frame_end,
  input  logic                     freeze,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_ack,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     disp_bank,
  output logic                     swap_pending,
  output logic [ADDR_W-1:0]        sram0_addr,
  output logic [DATA_W-1:0]        sram0_dq_out,
  input  logic [DATA_W-1:0]        sram0_dq_in,
  output logic                     sram0_dq_oe,
  output logic                     sram0_ce_n,
  output logic                     sram0_we_n,
  output logic                     sram0_oe_n,
  output logic [ADDR_W-1:0]        sram1_addr,
  output logic [DATA_W-1:0]        sram1_dq_out,
  input  logic [DATA_W-1:0]        sram1_dq_in,
  output logic                     sram1_dq_oe,
  output logic                     sram1_ce_n,
  output logic                     sram1_we_n,
  output logic                     sram1_oe_n
);

  localparam int PTR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  // Lowest requesting index strictly after ptr, wrapping; MSB = any found
  function automatic logic [PTR_W:0] rr_pick(input logic [PTR_W-1:0] ptr,
                                             input logic [NUM_RD-1:0] req);
    logic             found;
    logic [PTR_W-1:0] idx;
    int               cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_RD; k++) begin
      cand = (int'(ptr) + k) % NUM_RD;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = PTR_W'(cand);
      end
    end
    return {found, idx};
  endfunction

  logic [PTR_W-1:0]  ptr_r;
  logic [PTR_W:0]    pick_s;
  logic [PTR_W-1:0]  rd_idx_s;
  logic [ADDR_W-1:0] rd_addr_sel_s;
  logic              rd_go_s, wr_go_s, swap_go_s, rd_fin_s, wr_fin_s;
  logic [1:0]        idle_s, fin_s, dir_s, start_s, start_dir_s;
  logic [ADDR_W-1:0] start_addr_s [2];
  logic [DATA_W-1:0] start_data_s [2];

  // Arbitration, swap eligibility and routing of grants to the two banks
  always_comb begin
    swap_go_s     = swap_pending & ~freeze & idle_s[0] & idle_s[1];
    pick_s        = rr_pick(ptr_r, rd_req);
    rd_idx_s      = pick_s[PTR_W-1:0];
    rd_addr_sel_s = rd_addr[rd_idx_s*ADDR_W +: ADDR_W];
    rd_go_s       = pick_s[PTR_W] & idle_s[disp_bank] & ~swap_go_s;
    wr_go_s       = wr_req & idle_s[~disp_bank] & ~swap_go_s;
    wr_fin_s      = (fin_s[0] & (dir_s[0] == DIR_WRITE)) | (fin_s[1] & (dir_s[1] == DIR_WRITE));
    rd_fin_s      = (fin_s[0] & (dir_s[0] == DIR_READ))  | (fin_s[1] & (dir_s[1] == DIR_READ));
    if (disp_bank == BANK0) begin
      start_s         = {wr_go_s, rd_go_s};
      start_dir_s     = {DIR_WRITE, DIR_READ};
      start_addr_s[0] = rd_addr_sel_s;
      start_addr_s[1] = wr_addr;
      start_data_s[0] = '0;
      start_data_s[1] = wr_data;
    end else begin
      start_s         = {rd_go_s, wr_go_s};
      start_dir_s     = {DIR_READ, DIR_WRITE};
      start_addr_s[0] = wr_addr;
      start_addr_s[1] = rd_addr_sel_s;
      start_data_s[0] = wr_data;
      start_data_s[1] = '0;
    end
  end

  // Bank mapping, swap request, RR pointer and client-facing completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_bank    <= BANK0;
      swap_pending <= 1'b0;
      ptr_r        <= PTR_W'(NUM_RD - 1);
      wr_ack       <= 1'b0;
      rd_ack       <= '0;
      rd_data      <= '0;
    end else begin
      if (swap_go_s) begin
        disp_bank    <= ~disp_bank;
        swap_pending <= 1'b0;
      end else if (wr_frame_end) begin
        swap_pending <= 1'b1;
      end
      if (rd_go_s) begin
        ptr_r <= rd_idx_s;
      end
      // ptr_r still names the owner of the in-flight read
      wr_ack <= wr_fin_s;
      rd_ack <= rd_fin_s ? (NUM_RD'(1'b1) << ptr_r) : '0;
      if (fin_s[0] && dir_s[0] == DIR_READ) begin
        rd_data <= sram0_dq_in;
      end else if (fin_s[1] && dir_s[1] == DIR_READ) begin
        rd_data <= sram1_dq_in;
      end
    end
  end

  sram_bank_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_CYC(ACC_CYC)) u_bank0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start_s[0]),
    .start_dir  (start_dir_s[0]),
    .start_addr (start_addr_s[0]),
    .start_data (start_data_s[0]),
    .idle       (idle_s[0]),
    .finish_s   (fin_s[0]),
    .dir        (dir_s[0]),
    .sram_addr  (sram0_addr),
    .sram_dq_out(sram0_dq_out),
    .sram_dq_oe (sram0_dq_oe),
    .sram_ce_n  (sram0_ce_n),
    .sram_we_n  (sram0_we_n),
    .sram_oe_n  (sram0_oe_n)
  );

  sram_bank_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_CYC(ACC_CYC)) u_bank1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start_s[1]),
    .start_dir  (start_dir_s[1]),
    .start_addr (start_addr_s[1]),
    .start_data (start_data_s[1]),
    .idle       (idle_s[1]),
    .finish_s   (fin_s[1]),
    .dir        (dir_s[1]),
    .sram_addr  (sram1_addr),
    .sram_dq_out(sram1_dq_out),
    .sram_dq_oe (sram1_dq_oe),
    .sram_ce_n  (sram1_ce_n),
    .sram_we_n  (sram1_we_n),
    .sram_oe_n  (sram1_oe_n)
  );

endmodule

// File: tb/tb_sram_pingpong_arbiter.sv
// Directed bench for sram_pingpong_arbiter (ADDR_W=20, DATA_W=16, NUM_RD=2, ACC_CYC=2).
// Outputs are sampled on the falling edge; the SRAM read model lives in tick().
module tb_sram_pingpong_arbiter;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int NUM_RD  = 2;
  localparam int ACC_CYC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     wr_req, wr_ack, wr_frame_end, freeze;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD-1:0]        rd_req, rd_ack;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic                     disp_bank, swap_pending;
  logic [ADDR_W-1:0]        sram0_addr, sram1_addr;
  logic [DATA_W-1:0]        sram0_dq_out, sram1_dq_out, sram0_dq_in, sram1_dq_in;
  logic                     sram0_dq_oe, sram0_ce_n, sram0_we_n, sram0_oe_n;
  logic                     sram1_dq_oe, sram1_ce_n, sram1_we_n, sram1_oe_n;

  int n_cmp = 0;
  int n_bad = 0;
  int ph0   = 0;
  int ph1   = 0;

  sram_pingpong_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_RD(NUM_RD), .ACC_CYC(ACC_CYC)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .wr_frame_end(wr_frame_end), .freeze(freeze),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .disp_bank(disp_bank), .swap_pending(swap_pending),
    .sram0_addr(sram0_addr), .sram0_dq_out(sram0_dq_out), .sram0_dq_in(sram0_dq_in),
    .sram0_dq_oe(sram0_dq_oe), .sram0_ce_n(sram0_ce_n), .sram0_we_n(sram0_we_n), .sram0_oe_n(sram0_oe_n),
    .sram1_addr(sram1_addr), .sram1_dq_out(sram1_dq_out), .sram1_dq_in(sram1_dq_in),
    .sram1_dq_oe(sram1_dq_oe), .sram1_ce_n(sram1_ce_n), .sram1_we_n(sram1_we_n), .sram1_oe_n(sram1_oe_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; memory returns garbage until the last ACCESS cycle
  task automatic tick();
    @(negedge clk);
    if (!sram0_oe_n) begin
      ph0++;
      sram0_dq_in = (ph0 == ACC_CYC) ? (16'h5A00 ^ sram0_addr[15:0]) : 16'hDEAD;
    end else begin
      ph0 = 0;
      sram0_dq_in = 16'hDEAD;
    end
    if (!sram1_oe_n) begin
      ph1++;
      sram1_dq_in = (ph1 == ACC_CYC) ? (16'h5A00 ^ sram1_addr[15:0]) : 16'hDEAD;
    end else begin
      ph1 = 0;
      sram1_dq_in = 16'hDEAD;
    end
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_frame_end = 1'b0;
    freeze = 1'b0; rd_req = '0; rd_addr = {20'h00200, 20'h00100};
    sram0_dq_in = 16'hDEAD; sram1_dq_in = 16'hDEAD;
    tick(); tick();
    check_eq("rst_ce0", {31'd0, sram0_ce_n}, 32'd1);
    check_eq("rst_ce1", {31'd0, sram1_ce_n}, 32'd1);
    check_eq("rst_oe1", {31'd0, sram1_dq_oe}, 32'd0);
    check_eq("rst_disp", {31'd0, disp_bank}, 32'd0);
    check_eq("rst_pend", {31'd0, swap_pending}, 32'd0);
    check_eq("rst_rdata", {16'd0, rd_data}, 32'd0);
    check_eq("rst_acks", {29'd0, wr_ack, rd_ack}, 32'd0);

    // Single write goes to bank 1 (write bank while bank 0 is displayed)
    rst = 1'b0; wr_req = 1'b1; wr_addr = 20'h00010; wr_data = 16'hA5A5;
    tick();
    check_eq("wr_we1_c1", {31'd0, sram1_we_n}, 32'd0);
    check_eq("wr_dqoe1", {31'd0, sram1_dq_oe}, 32'd1);
    check_eq("wr_dq1", {16'd0, sram1_dq_out}, 32'h0000A5A5);
    check_eq("wr_addr1", {12'd0, sram1_addr}, 32'h00000010);
    check_eq("wr_ce0_idle", {31'd0, sram0_ce_n}, 32'd1);
    check_eq("wr_ack_c1", {31'd0, wr_ack}, 32'd0);
    tick();
    check_eq("wr_we1_c2", {31'd0, sram1_we_n}, 32'd0);
    check_eq("wr_ack_c2", {31'd0, wr_ack}, 32'd0);
    tick();
    check_eq("wr_we1_c3", {31'd0, sram1_we_n}, 32'd1);
    check_eq("wr_ack_c3", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    tick();
    check_eq("wr_ack_c4", {31'd0, wr_ack}, 32'd0);

    // Both readers held: round robin alternates starting at client 0
    rd_req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      tick();
      check_eq("rd_oe0", {31'd0, sram0_oe_n}, 32'd0);
      check_eq("rd_addr0", {12'd0, sram0_addr}, (g % 2 == 1) ? 32'h200 : 32'h100);
      tick(); tick();
      check_eq("rd_ack", {30'd0, rd_ack}, (g % 2 == 1) ? 32'd2 : 32'd1);
      check_eq("rd_data", {16'd0, rd_data}, (g % 2 == 1) ? 32'h5800 : 32'h5B00);
      check_eq("rd_bank1_idle", {31'd0, sram1_ce_n}, 32'd1);
      if (g == 3) rd_req = 2'b00;
      tick();
      check_eq("rd_ack_gap", {30'd0, rd_ack}, 32'd0);
    end

    // Frame end with both banks idle: swap one cycle later
    wr_frame_end = 1'b1;
    tick();
    wr_frame_end = 1'b0;
    check_eq("sw_pend", {31'd0, swap_pending}, 32'd1);
    check_eq("sw_disp_old", {31'd0, disp_bank}, 32'd0);
    tick();
    check_eq("sw_disp_new", {31'd0, disp_bank}, 32'd1);
    check_eq("sw_pend_clr", {31'd0, swap_pending}, 32'd0);
    wr_req = 1'b1; wr_addr = 20'h00020; wr_data = 16'h1234;
    tick();
    check_eq("sw_wr_we0", {31'd0, sram0_we_n}, 32'd0);
    check_eq("sw_wr_dq0", {16'd0, sram0_dq_out}, 32'h1234);
    check_eq("sw_wr_ce1", {31'd0, sram1_ce_n}, 32'd1);
    tick(); tick();
    check_eq("sw_wr_ack", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    tick();

    // Freeze holds the pending swap indefinitely
    freeze = 1'b1; wr_frame_end = 1'b1;
    tick();
    wr_frame_end = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check_eq("frz_pend", {31'd0, swap_pending}, 32'd1);
      check_eq("frz_disp", {31'd0, disp_bank}, 32'd1);
    end
    freeze = 1'b0;
    tick();
    check_eq("frz_rel_disp", {31'd0, disp_bank}, 32'd0);
    check_eq("frz_rel_pend", {31'd0, swap_pending}, 32'd0);

    // Frame end during a read: swap waits for the read to finish
    rd_req = 2'b10;
    tick();
    check_eq("dfr_oe_c1", {31'd0, sram0_oe_n}, 32'd0);
    wr_frame_end = 1'b1;
    tick();
    wr_frame_end = 1'b0;
    check_eq("dfr_pend", {31'd0, swap_pending}, 32'd1);
    check_eq("dfr_oe_c2", {31'd0, sram0_oe_n}, 32'd0);
    check_eq("dfr_disp_c2", {31'd0, disp_bank}, 32'd0);
    tick();
    check_eq("dfr_ack", {30'd0, rd_ack}, 32'd2);
    check_eq("dfr_data", {16'd0, rd_data}, 32'h5800);
    check_eq("dfr_disp_c3", {31'd0, disp_bank}, 32'd0);
    check_eq("dfr_oe_c3", {31'd0, sram0_oe_n}, 32'd1);
    rd_req = 2'b00;
    tick();
    check_eq("dfr_disp_idle", {31'd0, disp_bank}, 32'd0);
    check_eq("dfr_pend_idle", {31'd0, swap_pending}, 32'd1);
    tick();
    check_eq("dfr_disp_sw", {31'd0, disp_bank}, 32'd1);
    check_eq("dfr_pend_sw", {31'd0, swap_pending}, 32'd0);

    // Async reset in the middle of accesses on both banks
    rd_req = 2'b01; wr_req = 1'b1; wr_addr = 20'h00030; wr_data = 16'h5555;
    tick();
    check_eq("ar_oe1_act", {31'd0, sram1_oe_n}, 32'd0);
    check_eq("ar_we0_act", {31'd0, sram0_we_n}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_ce0", {31'd0, sram0_ce_n}, 32'd1);
    check_eq("ar_ce1", {31'd0, sram1_ce_n}, 32'd1);
    check_eq("ar_we0", {31'd0, sram0_we_n}, 32'd1);
    check_eq("ar_oe1", {31'd0, sram1_oe_n}, 32'd1);
    check_eq("ar_dqoe0", {31'd0, sram0_dq_oe}, 32'd0);
    rd_req = 2'b00; wr_req = 1'b0;
    tick();
    check_eq("ar_acks_rst", {29'd0, wr_ack, rd_ack}, 32'd0);
    tick();
    rst = 1'b0;
    check_eq("ar_disp", {31'd0, disp_bank}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ar_acks_post", {29'd0, wr_ack, rd_ack}, 32'd0);
    end

    // Request in the swap cycle is not granted; it lands on the new write bank
    wr_frame_end = 1'b1;
    tick();
    wr_frame_end = 1'b0;
    wr_req = 1'b1; wr_addr = 20'h00040; wr_data = 16'h0F0F;
    tick();
    check_eq("sg_disp", {31'd0, disp_bank}, 32'd1);
    check_eq("sg_ce0", {31'd0, sram0_ce_n}, 32'd1);
    check_eq("sg_ce1", {31'd0, sram1_ce_n}, 32'd1);
    tick();
    check_eq("sg_we0", {31'd0, sram0_we_n}, 32'd0);
    check_eq("sg_addr0", {12'd0, sram0_addr}, 32'h40);
    check_eq("sg_ce1_b", {31'd0, sram1_ce_n}, 32'd1);
    tick(); tick();
    check_eq("sg_ack", {31'd0, wr_ack}, 32'd1);
    wr_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
